cpu_fetch_unit: RTL and testbench

- Instruction-fetch stage; producer side of the fetch-to-decode interface that the decode stage consumes.
- Issues word-addressed requests to instruction memory and buffers in-order responses in a small FIFO.
- Presents {instr, pc, next_PC} to decode with a valid/ready handshake.
- Accepts branch redirects from execute, squashing buffered and in-flight instructions.

---
 rtl/cpu_fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_cpu_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch stage: credit-limited word requests to instruction memory, in-order
// response buffering, valid/ready hand-off to decode and redirect squashing.

module cpu_fetch_unit_chk #(
    parameter int CW    = 2,
    parameter int DEPTH = 2
) (
    input logic          clock,
    input logic          reset,
    input logic [CW-1:0] count,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] drop_cnt,
    input logic          rsp_push,
    input logic          dec_pop
);
    localparam logic [CW:0] FULL_C = (CW+1)'(DEPTH);

    a_no_push_full: assert property (@(posedge clock) disable iff (!reset)
        !(rsp_push && !dec_pop && ({1'b0, count} == FULL_C)));
    a_credit_bound: assert property (@(posedge clock) disable iff (!reset)
        (({1'b0, outstanding} + {1'b0, count}) <= FULL_C));
    a_drop_bound: assert property (@(posedge clock) disable iff (!reset)
        (drop_cnt <= outstanding));
endmodule

module cpu_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              PC_STEP  = 1,
    parameter int              DEPTH    = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_next_PC,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    localparam int              PW       = $clog2(DEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [CW:0]     DEPTH_C  = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]   PTR_ZERO = PW'(0);
    localparam logic [XLEN-1:0] STEP_C   = XLEN'(PC_STEP);

    logic            active_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   pcf_rd_q, pcf_rd_d, pcf_wr_q, pcf_wr_d;
    logic [XLEN-1:0] pcf_mem_q   [DEPTH];
    logic [ILEN-1:0] buf_instr_q [DEPTH];
    logic [XLEN-1:0] buf_pc_q    [DEPTH];
    logic [XLEN-1:0] buf_npc_q   [DEPTH];

    logic [CW:0]     occupancy_s;
    logic            req_fire_s, rsp_fire_s, rsp_push_s, dec_pop_s;
    logic [PW-1:0]   head_idx_s;
    logic [XLEN-1:0] rsp_pc_s;

    // Handshake qualifiers; a response with nothing outstanding is stray and ignored.
    always_comb begin
        occupancy_s    = {1'b0, outstanding_q} + {1'b0, count_q};
        imem_req_valid = active_q && (occupancy_s < DEPTH_C) && !redirect_valid;
        req_fire_s     = imem_req_valid && imem_req_ready;
        rsp_fire_s     = imem_rsp_valid && (outstanding_q != CNT_ZERO);
        rsp_push_s     = rsp_fire_s && (drop_cnt_q == CNT_ZERO) && !redirect_valid;
        dec_pop_s      = (count_q != CNT_ZERO) && dec_ready && !redirect_valid;
        rsp_pc_s       = pcf_mem_q[pcf_rd_q];
    end

    // When empty, show the slot just behind the head so dec_* keep their last value.
    always_comb begin
        if (count_q != CNT_ZERO) begin
            head_idx_s = rd_ptr_q;
        end else begin
            head_idx_s = rd_ptr_q - PTR_ONE;
        end
    end

    assign imem_req_addr = active_q ? fetch_pc_q : {XLEN{1'b0}};
    assign dec_valid     = (count_q != CNT_ZERO);
    assign dec_instr     = buf_instr_q[head_idx_s];
    assign dec_pc        = buf_pc_q[head_idx_s];
    assign dec_next_PC   = buf_npc_q[head_idx_s];

    // Next-state for PC, credit counters and FIFO pointers; redirect overrides all else.
    always_comb begin
        outstanding_d = outstanding_q + (req_fire_s ? CNT_ONE : CNT_ZERO)
                                      - (rsp_fire_s ? CNT_ONE : CNT_ZERO);
        pcf_wr_d      = pcf_wr_q + (req_fire_s ? PTR_ONE : PTR_ZERO);
        pcf_rd_d      = pcf_rd_q + (rsp_fire_s ? PTR_ONE : PTR_ZERO);
        fetch_pc_d    = fetch_pc_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            drop_cnt_d = outstanding_q - (rsp_fire_s ? CNT_ONE : CNT_ZERO);
            count_d    = CNT_ZERO;
            // Step past the discarded head so the empty view still shows it.
            if (count_q != CNT_ZERO) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                wr_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
                wr_ptr_d = wr_ptr_q;
            end
        end else begin
            fetch_pc_d = req_fire_s ? (fetch_pc_q + STEP_C) : fetch_pc_q;
            drop_cnt_d = (rsp_fire_s && (drop_cnt_q != CNT_ZERO)) ? (drop_cnt_q - CNT_ONE)
                                                                   : drop_cnt_q;
            count_d    = count_q + (rsp_push_s ? CNT_ONE : CNT_ZERO)
                                 - (dec_pop_s  ? CNT_ONE : CNT_ZERO);
            rd_ptr_d   = rd_ptr_q + (dec_pop_s  ? PTR_ONE : PTR_ZERO);
            wr_ptr_d   = wr_ptr_q + (rsp_push_s ? PTR_ONE : PTR_ZERO);
        end
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_q      <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= CNT_ZERO;
            drop_cnt_q    <= CNT_ZERO;
            count_q       <= CNT_ZERO;
            rd_ptr_q      <= PTR_ZERO;
            wr_ptr_q      <= PTR_ZERO;
            pcf_rd_q      <= PTR_ZERO;
            pcf_wr_q      <= PTR_ZERO;
        end else begin
            active_q      <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            pcf_rd_q      <= pcf_rd_d;
            pcf_wr_q      <= pcf_wr_d;
        end
    end

    // Request-address FIFO and instruction buffer storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pcf_mem_q[i]   <= {XLEN{1'b0}};
                buf_instr_q[i] <= {ILEN{1'b0}};
                buf_pc_q[i]    <= {XLEN{1'b0}};
                buf_npc_q[i]   <= {XLEN{1'b0}};
            end
        end else begin
            if (req_fire_s) begin
                pcf_mem_q[pcf_wr_q] <= fetch_pc_q;
            end
            if (rsp_push_s) begin
                buf_instr_q[wr_ptr_q] <= imem_rsp_data;
                buf_pc_q[wr_ptr_q]    <= rsp_pc_s;
                buf_npc_q[wr_ptr_q]   <= rsp_pc_s + STEP_C;
            end
        end
    end

    cpu_fetch_unit_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
        .clock       (clock),
        .reset       (reset),
        .count       (count_q),
        .outstanding (outstanding_q),
        .drop_cnt    (drop_cnt_q),
        .rsp_push    (rsp_push_s),
        .dec_pop     (dec_pop_s)
    );
endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Randomized bench for cpu_fetch_unit against a queue-level fetch model, plus a
// DEPTH=4 instance starting at 0xFFFF_FFFF for wrap and full-rate streaming.
module tb_cpu_fetch_unit;
    localparam int DEPTH = 2;
    localparam logic [31:0] PRE4 = {7'h1, 5'h0, 5'h2, 5'h1, 10'h0};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        dec_valid, dec_ready, redirect_valid;
    logic [31:0] imem_req_addr, imem_rsp_data, dec_instr, dec_pc, dec_next_PC, redirect_pc;
    logic        w_req_valid, w_rsp_valid, w_dec_valid;
    logic [31:0] w_req_addr, w_rsp_data, w_dec_instr, w_dec_pc, w_dec_npc;

    always #5 clock = ~clock;

    cpu_fetch_unit #(.DEPTH(DEPTH)) u_dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_next_PC(dec_next_PC),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    cpu_fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .DEPTH(4)) u_wrap (
        .clock(clock), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(w_rsp_data), .dec_valid(w_dec_valid), .dec_ready(1'b1),
        .dec_instr(w_dec_instr), .dec_pc(w_dec_pc), .dec_next_PC(w_dec_npc),
        .redirect_valid(1'b0), .redirect_pc(32'h0)
    );

    typedef struct packed { logic [31:0] instr; logic [31:0] pc; logic [31:0] npc; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    ent_t        m_buf[$];
    ent_t        m_last;
    logic [31:0] m_pcq[$];
    mreq_t       mq[$];
    logic [31:0] m_pc, w_pend_addr, tgt;
    logic [31:0] pops[$];
    logic        m_active, w_pend, wait_tgt, seen4, done;
    int          m_out, m_drop, cyc, kk, lat, ph, chk, err;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'd4) ? PRE4 : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        dec_ready = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_req_valid"}, 64'(imem_req_valid), 64'(1'b0));
        cmp({tag, "_req_addr"},  64'(imem_req_addr),  64'(32'h0));
        cmp({tag, "_dec_valid"}, 64'(dec_valid),      64'(1'b0));
        cmp({tag, "_dec_instr"}, 64'(dec_instr),      64'(32'h0));
        cmp({tag, "_dec_pc"},    64'(dec_pc),         64'(32'h0));
        cmp({tag, "_dec_npc"},   64'(dec_next_PC),    64'(32'h0));
        cmp({tag, "_w_req_addr"}, 64'(w_req_addr),    64'(32'h0));
        cmp({tag, "_w_dec_valid"}, 64'(w_dec_valid),  64'(1'b0));
    endtask

    // Entered just after a negedge; leaves just after a negedge with reset released.
    task automatic do_reset(input bit mid);
        if (mid) begin
            #2;
            reset = 1'b0;
            #1;
            check_zero("async_rst");
        end else begin
            reset = 1'b0;
        end
        idle_inputs();
        @(negedge clock);
        @(negedge clock);
        check_zero("in_rst");
        m_pc = 32'h0; m_out = 0; m_drop = 0; m_active = 1'b0; m_last = '0;
        m_buf.delete(); m_pcq.delete(); mq.delete();
        w_pend = 1'b0; w_pend_addr = 32'h0; kk = 0; wait_tgt = 1'b0;
        reset = 1'b1;
    endtask

    // One cycle: drive, compare every output against the model, advance the model.
    task automatic step(input logic drdy, input logic rrdy, input logic redir,
                        input logic [31:0] rpc);
        logic        rv, exp_rv, rf, qf, pop;
        logic [31:0] rd, old_pc, ea, wexp;
        ent_t        sh;
        rv = (mq.size() != 0) && (mq[0].due <= cyc);
        rd = rv ? mem_rd(mq[0].addr) : 32'h0;
        dec_ready = drdy; imem_req_ready = rrdy; redirect_valid = redir; redirect_pc = rpc;
        imem_rsp_valid = rv; imem_rsp_data = rd;
        w_rsp_valid = w_pend; w_rsp_data = mem_rd(w_pend_addr);
        #1;
        exp_rv = m_active && ((m_out + m_buf.size()) < DEPTH) && !redir;
        ea     = m_active ? m_pc : 32'h0;
        sh     = (m_buf.size() != 0) ? m_buf[0] : m_last;
        cmp("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        cmp("req_addr",  64'(imem_req_addr),  64'(ea));
        cmp("dec_valid", 64'(dec_valid), 64'(m_buf.size() != 0));
        cmp("dec_instr", 64'(dec_instr), 64'(sh.instr));
        cmp("dec_pc",    64'(dec_pc),    64'(sh.pc));
        cmp("dec_npc",   64'(dec_next_PC), 64'(sh.npc));
        if (dec_valid && (dec_pc == 32'd4)) begin
            cmp("instr_at_4", 64'(dec_instr), 64'(PRE4));
            seen4 = 1'b1;
        end
        if ((ph == 1 || ph == 6) && kk == 1) begin
            cmp("first_req_valid", 64'(imem_req_valid), 64'(1'b1));
            cmp("first_req_addr",  64'(imem_req_addr),  64'(32'h0));
        end
        if (ph == 1 && kk == 3) begin
            cmp("first_dec_valid", 64'(dec_valid),   64'(1'b1));
            cmp("first_dec_pc",    64'(dec_pc),      64'(32'h0));
            cmp("first_dec_npc",   64'(dec_next_PC), 64'(32'h1));
        end
        if (ph == 2 && kk >= 4 && kk <= 7) begin
            cmp("stall_dec_valid", 64'(dec_valid),      64'(1'b1));
            cmp("stall_dec_pc",    64'(dec_pc),         64'(32'h0));
            cmp("stall_req_valid", 64'(imem_req_valid), 64'(1'b0));
        end
        if (ph == 2 && dec_valid && drdy) pops.push_back(dec_pc);
        if (wait_tgt && dec_valid) begin
            cmp("redir_dec_pc",    64'(dec_pc),      64'(tgt));
            cmp("redir_dec_npc",   64'(dec_next_PC), 64'(tgt + 32'd1));
            cmp("redir_dec_instr", 64'(dec_instr),   64'(mem_rd(tgt)));
            wait_tgt = 1'b0;
        end
        if (ph == 1 && kk < 11) begin
            if (kk < 3) begin
                cmp("wrap_idle", 64'(w_dec_valid), 64'(1'b0));
            end else begin
                wexp = 32'hFFFF_FFFF + 32'(kk - 3);
                cmp("wrap_valid", 64'(w_dec_valid), 64'(1'b1));
                cmp("wrap_pc",    64'(w_dec_pc),    64'(wexp));
                cmp("wrap_npc",   64'(w_dec_npc),   64'(32'(kk - 3)));
                cmp("wrap_instr", 64'(w_dec_instr), 64'(mem_rd(wexp)));
            end
        end
        rf = exp_rv && rrdy;
        qf = rv && (m_out > 0);
        pop = (m_buf.size() != 0) && drdy && !redir;
        old_pc = m_pc;
        if (redir) begin
            m_pc = rpc;
            m_drop = m_out - (qf ? 1 : 0);
            m_buf.delete();
        end else begin
            if (rf) m_pc = m_pc + 32'd1;
            if (pop) void'(m_buf.pop_front());
            if (qf) begin
                if (m_drop > 0) m_drop--;
                else m_buf.push_back({rd, m_pcq[0], m_pcq[0] + 32'd1});
            end
        end
        if (qf) void'(m_pcq.pop_front());
        if (rv) void'(mq.pop_front());
        if (rf) begin
            m_pcq.push_back(old_pc);
            mq.push_back('{addr: old_pc, due: cyc + lat});
        end
        m_out = m_out + (rf ? 1 : 0) - (qf ? 1 : 0);
        m_last = sh;
        m_active = 1'b1;
        w_pend = w_req_valid;
        w_pend_addr = w_req_addr;
        cyc++;
        kk++;
        @(negedge clock);
    endtask

    initial begin
        logic r_drdy, r_rrdy, r_redir;
        logic [31:0] r_pc;
        chk = 0; err = 0; cyc = 0; kk = 0; seen4 = 1'b0; done = 1'b0;
        wait_tgt = 1'b0; tgt = 32'h0;
        idle_inputs();

        ph = 1; lat = 1; do_reset(1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        cmp("seen_instr4", 64'(seen4), 64'(1'b1));

        ph = 2; do_reset(1'b0); pops.delete();
        for (int i = 0; i < 20; i++) step((i < 3) || (i > 7), 1'b1, 1'b0, 32'h0);
        cmp("stall_pops", 64'(pops.size() >= 3), 64'(1'b1));
        if (pops.size() >= 3)
            for (int i = 0; i < 3; i++) cmp("stall_order", 64'(pops[i]), 64'(32'(i)));

        ph = 3; lat = 3; do_reset(1'b0); done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!done && m_out == 2) begin
                step(1'b1, 1'b1, 1'b1, 32'h40);
                cmp("drop_two", 64'(m_drop), 64'(2));
                tgt = 32'h40; wait_tgt = 1'b1; done = 1'b1;
            end else begin
                step(1'b1, 1'b1, 1'b0, 32'h0);
            end
        end
        cmp("redir3_fired", 64'(done), 64'(1'b1));
        cmp("redir3_delivered", 64'(wait_tgt), 64'(1'b0));

        ph = 4; lat = 1; do_reset(1'b0); done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!done && mq.size() != 0 && mq[0].due <= cyc && m_buf.size() != 0) begin
                step(1'b1, 1'b1, 1'b1, 32'h80);
                cmp("drop_minus_one", 64'(m_drop), 64'(0));
                tgt = 32'h80; wait_tgt = 1'b1; done = 1'b1;
            end else begin
                step(1'b1, 1'b1, 1'b0, 32'h0);
            end
        end
        cmp("redir4_fired", 64'(done), 64'(1'b1));
        cmp("redir4_delivered", 64'(wait_tgt), 64'(1'b0));

        ph = 5; do_reset(1'b0);
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                do_reset(1'b1);
                ph = 6;
            end
            lat = $urandom_range(1, 3);
            r_drdy = ($urandom_range(0, 9) < 7);
            r_rrdy = ($urandom_range(0, 3) != 0);
            r_redir = (kk >= 2) && ($urandom_range(0, 19) == 0);
            r_pc = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFE : $urandom;
            step(r_drdy, r_rrdy, r_redir, r_pc);
        end

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
